// File: rtl/tbox_auto_player.sv
// tbox_auto_player: automatic tic-tac-toe opponent.
// Scans win, block, then preference order and issues one set pulse.
module tbox_auto_player #(
  parameter bit          MY_SYMBOL   = 1'b0,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
    SCAN_BLK,
    PREF,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic [3:0] TMO = 4'(ACK_TIMEOUT);

  // entry i (4 bits) is the i-th preferred cell
  localparam logic [35:0] PREF_ORDER = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8,
    4'd6, 4'd2, 4'd0, 4'd4
  };

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_NP  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  function automatic logic [11:0] line_cells(
    input logic [2:0] l
  );
    case (l)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [3:0] cell_rc(
    input logic [3:0] c
  );
    case (c)
      4'd0:    cell_rc = 4'b0101;
      4'd1:    cell_rc = 4'b0110;
      4'd2:    cell_rc = 4'b0111;
      4'd3:    cell_rc = 4'b1001;
      4'd4:    cell_rc = 4'b1010;
      4'd5:    cell_rc = 4'b1011;
      4'd6:    cell_rc = 4'b1101;
      4'd7:    cell_rc = 4'b1110;
      4'd8:    cell_rc = 4'b1111;
      default: cell_rc = 4'b0000;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cell_q, cell_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       set_q, set_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] err_q, err_d;

  logic [3:0] ca, cb, cc;
  logic       scan_sym;
  logic       ma, mb, mc;
  logic       ea, eb, ec;
  logic       hit;
  logic [3:0] hit_cell;
  logic       pref_ok;
  logic [3:0] pref_cell;
  logic       my_turn;
  logic       playable;
  logic       acked;

  always_comb begin
    {ca, cb, cc} = line_cells(idx_q);
    scan_sym = (state_q == SCAN_BLK) ?
               ~MY_SYMBOL : MY_SYMBOL;
    ma = valid[ca] && (symbol[ca] == scan_sym);
    mb = valid[cb] && (symbol[cb] == scan_sym);
    mc = valid[cc] && (symbol[cc] == scan_sym);
    ea = !valid[ca];
    eb = !valid[cb];
    ec = !valid[cc];
    hit      = 1'b0;
    hit_cell = 4'd0;
    if (ma && mb && ec) begin
      hit      = 1'b1;
      hit_cell = cc;
    end else if (ma && mc && eb) begin
      hit      = 1'b1;
      hit_cell = cb;
    end else if (mb && mc && ea) begin
      hit      = 1'b1;
      hit_cell = ca;
    end
  end

  // walk backwards so the earliest preferred empty cell wins
  always_comb begin
    pref_ok   = 1'b0;
    pref_cell = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (!valid[PREF_ORDER[i*4 +: 4]]) begin
        pref_ok   = 1'b1;
        pref_cell = PREF_ORDER[i*4 +: 4];
      end
    end
  end

  // X moves on an even count, so parity equals O's turn
  assign my_turn  = (^valid) ^ MY_SYMBOL;
  assign playable = (game_state == 2'b00) && my_turn;
  assign acked    = valid[cell_q] &&
                    (symbol[cell_q] == MY_SYMBOL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cell_d  = cell_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    set_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (!playable) begin
            state_d = DONE;
            err_d   = ERR_NP;
          end else begin
            state_d = SCAN_WIN;
            idx_d   = 3'd0;
            err_d   = ERR_OK;
          end
        end
      end
      SCAN_WIN, SCAN_BLK: begin
        if (hit) begin
          state_d        = ISSUE;
          cell_d         = hit_cell;
          {row_d, col_d} = cell_rc(hit_cell);
          set_d          = 1'b1;
        end else if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = (state_q == SCAN_WIN) ?
                    SCAN_BLK : PREF;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      PREF: begin
        if (pref_ok) begin
          state_d        = ISSUE;
          cell_d         = pref_cell;
          {row_d, col_d} = cell_rc(pref_cell);
          set_d          = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = ERR_NP;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 4'd0;
      end
      WAIT: begin
        if (acked) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = ERR_OK;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TMO) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = ERR_TMO;
          end
        end
      end
      DONE: begin
        // an early reject arrives without done and reports a cycle later
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          row_d   = 2'b00;
          col_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cell_q  <= 4'd0;
      cnt_q   <= 4'd0;
      row_q   <= 2'b00;
      col_q   <= 2'b00;
      set_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cell_q  <= cell_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign set  = set_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_tbox_auto_player.sv
// tb_tbox_auto_player: directed checks of the auto player
// against a small board stub, one X player and one O player.
module tb_tbox_auto_player;

  logic       clk;
  logic       reset_n;
  logic       start_x, start_o;
  logic [8:0] valid, symbol;
  logic [1:0] game_state;
  logic [1:0] row_x, col_x, err_x;
  logic [1:0] row_o, col_o, err_o;
  logic       set_x, busy_x, done_x;
  logic       set_o, busy_o, done_o;

  tbox_auto_player #(
    .MY_SYMBOL(1'b1),
    .ACK_TIMEOUT(4)
  ) dut_x (
    .clk(clk),
    .reset_n(reset_n),
    .start(start_x),
    .valid(valid),
    .symbol(symbol),
    .game_state(game_state),
    .row(row_x),
    .col(col_x),
    .set(set_x),
    .busy(busy_x),
    .done(done_x),
    .err(err_x)
  );

  tbox_auto_player #(
    .MY_SYMBOL(1'b0),
    .ACK_TIMEOUT(4)
  ) dut_o (
    .clk(clk),
    .reset_n(reset_n),
    .start(start_o),
    .valid(valid),
    .symbol(symbol),
    .game_state(game_state),
    .row(row_o),
    .col(col_o),
    .set(set_o),
    .busy(busy_o),
    .done(done_o),
    .err(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit         sel_x;
  logic [1:0] o_row, o_col, o_err;
  logic       o_set, o_busy, o_done;
  assign o_row  = sel_x ? row_x  : row_o;
  assign o_col  = sel_x ? col_x  : col_o;
  assign o_err  = sel_x ? err_x  : err_o;
  assign o_set  = sel_x ? set_x  : set_o;
  assign o_busy = sel_x ? busy_x : busy_o;
  assign o_done = sel_x ? done_x : done_o;

  localparam int LN [24] = '{
    0, 1, 2,  3, 4, 5,  6, 7, 8,
    0, 3, 6,  1, 4, 7,  2, 5, 8,
    0, 4, 8,  2, 4, 6
  };

  function automatic logic [1:0] judge(
    input logic [8:0] v, input logic [8:0] s
  );
    for (int l = 0; l < 8; l++) begin
      if (v[LN[3*l]] && v[LN[3*l+1]] && v[LN[3*l+2]] &&
          s[LN[3*l]] == s[LN[3*l+1]] &&
          s[LN[3*l]] == s[LN[3*l+2]])
        return s[LN[3*l]] ? 2'b01 : 2'b10;
    end
    return (&v) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [3:0] rc2k(
    input logic [1:0] r, input logic [1:0] c
  );
    return 4'(({2'b00, r} - 4'd1) * 4'd3 +
              {2'b00, c} - 4'd1);
  endfunction

  // board stub: latches a move on the edge that samples set
  logic       ld, ack_en;
  logic [8:0] ld_v, ld_s;
  logic [1:0] ld_g;

  always @(posedge clk) begin
    logic [8:0] nv, ns;
    logic [3:0] k;
    if (ld) begin
      valid      <= ld_v;
      symbol     <= ld_s;
      game_state <= ld_g;
    end else if (ack_en && (set_x || set_o)) begin
      nv = valid;
      ns = symbol;
      k  = set_x ? rc2k(row_x, col_x) : rc2k(row_o, col_o);
      nv[k] = 1'b1;
      ns[k] = set_x;
      valid      <= nv;
      symbol     <= ns;
      game_state <= judge(nv, ns);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  task automatic load(
    input logic [8:0] v, input logic [8:0] s,
    input logic [1:0] g
  );
    ld_v = v;
    ld_s = s;
    ld_g = g;
    ld   = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // start one move; returns after the edge that raised done
  task automatic do_move(
    input bit use_x, input int max_e,
    output int set_e, output int set_n,
    output logic [3:0] rc, output int done_e,
    output logic [1:0] e_code, output bit busy_ok
  );
    set_e = -1; set_n = 0; rc = 4'd0;
    done_e = -1; e_code = 2'b00; busy_ok = 1'b1;
    sel_x = use_x;
    if (use_x) start_x = 1'b1;
    else start_o = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
    start_o = 1'b0;
    for (int e = 0; e <= max_e; e++) begin
      if (!o_busy) busy_ok = 1'b0;
      if (o_set) begin
        set_n++;
        if (set_e < 0) begin
          set_e = e;
          rc = {o_row, o_col};
        end
      end
      if (o_done) begin
        done_e = e;
        e_code = o_err;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int         se, sn, de;
  logic [3:0] rc;
  logic [1:0] ec;
  bit         bok;
  int         glitch;

  localparam logic [8:0] V3 = 9'b000011011;
  localparam logic [8:0] S3 = 9'b000000011;

  initial begin
    reset_n = 1'b0;
    start_x = 1'b0;
    start_o = 1'b0;
    ld = 1'b0;
    ack_en = 1'b1;
    ld_v = '0; ld_s = '0; ld_g = '0;
    sel_x = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", {row_x, col_x, set_x, busy_x, done_x, err_x}, 0);
    check("rst_o", {row_o, col_o, set_o, busy_o, done_o, err_o}, 0);
    reset_n = 1'b1;

    // 1: empty board, X takes the centre via PREF
    load(9'd0, 9'd0, 2'b00);
    do_move(1'b1, 40, se, sn, rc, de, ec, bok);
    check("t1_set_edge", se, 17);
    check("t1_rc", rc, 4'b1010);
    check("t1_set_cnt", sn, 1);
    check("t1_done_edge", de, 19);
    check("t1_err", ec, 2'b00);
    check("t1_busy", bok, 1);
    @(posedge clk);
    #1;
    check("t1_idle", {o_busy, o_row, o_col}, 0);

    // 2: O blocks X on line {0,3,6}
    load(9'b001010001, 9'b001000001, 2'b00);
    do_move(1'b0, 40, se, sn, rc, de, ec, bok);
    check("t2_set_edge", se, 12);
    check("t2_rc", rc, 4'b1001);
    check("t2_done_edge", de, 14);
    check("t2_err", ec, 2'b00);
    @(posedge clk);
    #1;

    // 3: X completes line 0 at cell 2
    load(V3, S3, 2'b00);
    do_move(1'b1, 40, se, sn, rc, de, ec, bok);
    check("t3_set_edge", se, 1);
    check("t3_rc", rc, 4'b0111);
    check("t3_done_edge", de, 3);
    check("t3_err", ec, 2'b00);
    check("t3_gstate", game_state, 2'b01);
    @(posedge clk);
    #1;

    // 4a: game already won
    do_move(1'b1, 40, se, sn, rc, de, ec, bok);
    check("t4a_set_cnt", sn, 0);
    check("t4a_done_edge", de, 1);
    check("t4a_err", ec, 2'b01);
    @(posedge clk);
    #1;

    // 4b: O on an empty board is out of turn
    load(9'd0, 9'd0, 2'b00);
    do_move(1'b0, 40, se, sn, rc, de, ec, bok);
    check("t4b_set_cnt", sn, 0);
    check("t4b_done_edge", de, 1);
    check("t4b_err", ec, 2'b01);
    @(posedge clk);
    #1;

    // 5: board never acknowledges
    ack_en = 1'b0;
    load(V3, S3, 2'b00);
    do_move(1'b1, 40, se, sn, rc, de, ec, bok);
    check("t5_set_edge", se, 1);
    check("t5_done_edge", de, 6);
    check("t5_err", ec, 2'b10);
    @(posedge clk);
    #1;
    check("t5_idle", {o_busy, o_row, o_col}, 0);
    check("t5_err_hold", o_err, 2'b10);
    ack_en = 1'b1;

    // 6a: reset during SCAN_BLK
    load(9'd0, 9'd0, 2'b00);
    sel_x = 1'b1;
    start_x = 1'b1;
    @(posedge clk);
    #1 start_x = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("t6a_busy_pre", o_busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6a_rst_out",
          {o_row, o_col, o_set, o_busy, o_done, o_err}, 0);
    glitch = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) reset_n = 1'b1;
      if (o_done || o_set) glitch++;
    end
    check("t6a_no_done", glitch, 0);

    // 6b: reset in the ISSUE cycle
    load(V3, S3, 2'b00);
    start_x = 1'b1;
    @(posedge clk);
    #1 start_x = 1'b0;
    @(posedge clk);
    #1;
    check("t6b_set_pre", o_set, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6b_rst_out",
          {o_row, o_col, o_set, o_busy, o_done, o_err}, 0);
    glitch = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) reset_n = 1'b1;
      if (o_done || o_set) glitch++;
    end
    check("t6b_no_done", glitch, 0);
    check("t6b_no_ack", valid, V3);

    // 6c: normal move after reset
    do_move(1'b1, 40, se, sn, rc, de, ec, bok);
    check("t6c_set_edge", se, 1);
    check("t6c_rc", rc, 4'b0111);
    check("t6c_done_edge", de, 3);
    check("t6c_err", ec, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
